// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the CPU step controller: mode codes, FSM states,
// step counter width and a helper that says which modes run the divider.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_STEP  = 2'b00,
    MODE_RUN   = 2'b01,
    MODE_BREAK = 2'b10,
    MODE_HOLD  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PULSE = 2'b01,
    ST_GAP   = 2'b10,
    ST_HALT  = 2'b11
  } state_e;

  localparam int STEP_CNT_W = 16;

  // RUN and BREAK are the modes that free-run the divider
  function automatic logic mode_ticks(input logic [1:0] m);
    return (m == MODE_RUN) || (m == MODE_BREAK);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, debounce counter, rise pulse.
// Ports: clk, reset (sync, high), btn (raw async), rise (1-cycle pulse).
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          s1;
  logic          s2;
  logic          level;
  logic [CW-1:0] cnt;
  logic          flip;

  // accept the new level on the Nth consecutive differing sample
  assign flip = (s2 != level) &&
                (cnt == CW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      s1   <= btn;
      s2   <= s1;
      rise <= flip & s2;
      if (flip)
        level <= s2;
      if ((s2 == level) || flip)
        cnt <= '0;
      else
        cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/cpu_step_ctrl.sv
// Controlled clock for the single-cycle CPU: step, run, run-to-break.
// Ports: clk, reset, btn_step, mode, bp_addr, cpu_pc -> cpu_clk, halted, step_count.
module cpu_step_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HIGH_CYCLES     = 4,
  parameter int RUN_DIV         = 5000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  btn_step,
  input  logic [1:0]            mode,
  input  logic [31:0]           bp_addr,
  input  logic [31:0]           cpu_pc,
  output logic                  cpu_clk,
  output logic                  halted,
  output logic [STEP_CNT_W-1:0] step_count
);

  localparam int DW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam int PW = $clog2(HIGH_CYCLES + 1);

  state_e                state;
  state_e                nstate;
  logic [PW-1:0]         ph;
  logic [DW-1:0]         div;
  logic [STEP_CNT_W-1:0] step_cnt;
  logic                  from_halt;
  logic                  step_req;
  logic                  tick_en;
  logic                  tick;
  logic                  phase_end;
  logic                  start;
  logic                  cpu_clk_d;
  logic                  halted_d;
  logic                  cpu_clk_q;
  logic                  halted_q;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_step),
    .rise (step_req)
  );

  // divider freezes in HALT so a stopped CPU gets no ticks
  assign tick_en   = mode_ticks(mode) && (state != ST_HALT);
  assign tick      = tick_en && (div == DW'(RUN_DIV - 1));
  assign phase_end = (ph == PW'(HIGH_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      ph        <= '0;
      div       <= '0;
      step_cnt  <= '0;
      from_halt <= 1'b0;
      cpu_clk_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state <= nstate;
      if ((nstate == state) &&
          ((state == ST_PULSE) || (state == ST_GAP)))
        ph <= ph + PW'(1);
      else
        ph <= '0;
      if (!mode_ticks(mode))
        div <= '0;
      else if (tick_en)
        div <= tick ? '0 : div + DW'(1);
      if (start) begin
        step_cnt  <= step_cnt + STEP_CNT_W'(1);
        from_halt <= (state == ST_HALT);
      end
      cpu_clk_q <= cpu_clk_d;
      halted_q  <= halted_d;
    end
  end

  always_comb begin
    nstate = state;
    unique case (state)
      ST_IDLE: begin
        if (((mode == MODE_STEP) && step_req) || tick)
          nstate = ST_PULSE;
      end
      ST_PULSE: begin
        if (phase_end)
          nstate = ST_GAP;
      end
      ST_GAP: begin
        if (phase_end) begin
          if ((mode == MODE_BREAK) &&
              ((cpu_pc == bp_addr) || from_halt))
            nstate = ST_HALT;
          else
            nstate = ST_IDLE;
        end
      end
      ST_HALT: begin
        if (mode != MODE_BREAK)
          nstate = ST_IDLE;
        else if (step_req)
          nstate = ST_PULSE;
      end
      default: nstate = ST_IDLE;
    endcase
  end

  // halted holds through a single step taken from HALT
  always_comb begin
    start     = (nstate == ST_PULSE) && (state != ST_PULSE);
    cpu_clk_d = (nstate == ST_PULSE);
    halted_d  = halted_q;
    if (nstate == ST_HALT)
      halted_d = 1'b1;
    else if (nstate == ST_IDLE)
      halted_d = 1'b0;
  end

  assign cpu_clk    = cpu_clk_q;
  assign halted     = halted_q;
  assign step_count = step_cnt;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl: vector table plus directed multi-cycle
// sequences for run, breakpoint, halted stepping, reset and wrap.
module tb_cpu_step_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btn_step = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [31:0] bp_addr = 32'hFFFF_FFFF;
  logic [31:0] cpu_pc = 32'h0;
  logic        cpu_clk;
  logic        halted;
  logic [15:0] step_count;

  int   nvec = 0;
  int   nerr = 0;
  logic last_clk = 1'b0;

  typedef struct {
    logic        rst;
    logic        btn;
    logic [1:0]  md;
    logic        e_clk;
    logic        e_halt;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tv[$];

  cpu_step_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .HIGH_CYCLES    (2),
    .RUN_DIV        (10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_step  (btn_step),
    .mode      (mode),
    .bp_addr   (bp_addr),
    .cpu_pc    (cpu_pc),
    .cpu_clk   (cpu_clk),
    .halted    (halted),
    .step_count(step_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic add(input int n, input logic r, input logic b,
                     input logic [1:0] m, input logic c,
                     input logic h, input logic [15:0] k);
    vec_t v;
    v.rst = r; v.btn = b; v.md = m;
    v.e_clk = c; v.e_halt = h; v.e_cnt = k;
    for (int i = 0; i < n; i++) tv.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // one clk cycle; CPU model bumps PC by 4 on each cpu_clk rise
  task automatic cyc(input logic r, input logic b, input logic [1:0] m);
    reset = r; btn_step = b; mode = m;
    @(posedge clk);
    #1;
    if (cpu_clk && !last_clk) cpu_pc = cpu_pc + 32'd4;
    last_clk = cpu_clk;
  endtask

  initial begin
    int n;
    int rises;
    int lows;

    // reset with button held, release, bouncy press, hold
    add(3, 1, 1, 2'b00, 0, 0, 16'd0);
    add(2, 0, 0, 2'b00, 0, 0, 16'd0);
    add(1, 0, 1, 2'b00, 0, 0, 16'd0);
    add(1, 0, 0, 2'b00, 0, 0, 16'd0);
    add(6, 0, 1, 2'b00, 0, 0, 16'd0);
    add(2, 0, 1, 2'b00, 1, 0, 16'd1);
    add(8, 0, 1, 2'b00, 0, 0, 16'd1);
    // RUN pulse, then a press whose step_req lands in GAP
    add(2, 1, 0, 2'b00, 0, 0, 16'd0);
    add(6, 0, 0, 2'b01, 0, 0, 16'd0);
    add(3, 0, 1, 2'b01, 0, 0, 16'd0);
    add(1, 0, 1, 2'b01, 1, 0, 16'd1);
    add(1, 0, 1, 2'b00, 1, 0, 16'd1);
    add(14, 0, 1, 2'b00, 0, 0, 16'd1);

    for (int i = 0; i < tv.size(); i++) begin
      cyc(tv[i].rst, tv[i].btn, tv[i].md);
      chk($sformatf("vec%0d", i),
          32'({cpu_clk, halted, step_count}),
          32'({tv[i].e_clk, tv[i].e_halt, tv[i].e_cnt}));
    end

    // RUN for 35 cycles with the button held: pulses at 10,20,30
    cyc(1, 0, 2'b00);
    cyc(1, 0, 2'b00);
    for (int i = 1; i <= 35; i++) begin
      cyc(0, 1, 2'b01);
      chk($sformatf("run_clk%0d", i), 32'(cpu_clk),
          32'((i >= 10) && ((i % 10 == 0) || (i % 10 == 1))));
    end
    chk("run_count", 32'(step_count), 32'd3);

    // run to breakpoint at PC 8
    cyc(1, 0, 2'b00);
    cyc(1, 0, 2'b00);
    cpu_pc = 32'h0;
    bp_addr = 32'h8;
    n = 61;
    for (int i = 1; i <= 60; i++) begin
      cyc(0, 0, 2'b10);
      if (halted) begin
        n = i;
        break;
      end
    end
    chk("halt_cycle", 32'(n), 32'd24);
    chk("halt_pc", cpu_pc, 32'h8);
    chk("halt_count", 32'(step_count), 32'd2);
    rises = 0;
    lows = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(0, 0, 2'b10);
      if (cpu_clk) rises++;
      if (!halted) lows++;
    end
    chk("halt_no_clk", 32'(rises), 32'd0);
    chk("halt_stays", 32'(lows), 32'd0);

    // single step from HALT, halted stays high
    for (int i = 1; i <= 12; i++) begin
      cyc(0, 1, 2'b10);
      chk($sformatf("hstep%0d", i), 32'({cpu_clk, halted}),
          32'({(i == 7) || (i == 8), 1'b1}));
    end
    chk("hstep_pc", cpu_pc, 32'hC);
    chk("hstep_count", 32'(step_count), 32'd3);

    // leave HALT via RUN
    cyc(0, 1, 2'b01);
    chk("resume_halted", 32'(halted), 32'd0);
    n = 0;
    for (int i = 1; i <= 15; i++) begin
      cyc(0, 1, 2'b01);
      if (cpu_clk) begin
        n = i;
        break;
      end
    end
    chk("resume_pulse", 32'(n != 0), 32'd1);
    chk("resume_count", 32'(step_count), 32'd4);

    // reset on second PULSE cycle
    cyc(1, 0, 2'b00);
    cyc(1, 0, 2'b00);
    for (int i = 0; i < 9; i++) cyc(0, 0, 2'b01);
    cyc(0, 0, 2'b01);
    chk("rp_first", 32'(cpu_clk), 32'd1);
    cyc(0, 0, 2'b01);
    chk("rp_second", 32'(cpu_clk), 32'd1);
    cyc(1, 0, 2'b01);
    chk("rp_reset", 32'({cpu_clk, step_count}), 32'd0);
    rises = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 2'b00);
      if (cpu_clk) rises++;
    end
    chk("rp_idle", 32'(rises), 32'd0);

    // counter wrap from 65535
    force dut.step_cnt = 16'hFFFF;
    cyc(0, 0, 2'b00);
    release dut.step_cnt;
    cyc(0, 0, 2'b00);
    chk("wrap_preload", 32'(step_count), 32'hFFFF);
    for (int i = 0; i < 10; i++) cyc(0, 0, 2'b01);
    chk("wrap_clk", 32'(cpu_clk), 32'd1);
    chk("wrap_count", 32'(step_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
